// File: rtl/filter_gpu_pkg.sv
// rtl/filter_gpu_pkg.sv - shared types and default sizes for the Filter-GPU EX/MEM stage
package filter_gpu_pkg;

   typedef struct packed {
      logic pcsrc;
      logic regwrite;
      logic memtoreg;
      logic memwrite;
   } ctrl_t;

   localparam int LANES_DEF = 3;
   localparam int N_DEF     = 18;
   localparam int RW_DEF    = 4;
   localparam int CW_DEF    = 16;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - enable-loaded EX/MEM payload register, cleared by async reset
module pipe_slot
   import filter_gpu_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int LANES = LANES_DEF,
   parameter int RW    = RW_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load_i,
   input  logic [LANES-1:0][N-1:0]   alu_i,
   input  logic [LANES-1:0][N-1:0]   dir2_i,
   input  logic [LANES-1:0][N-1:0]   dir3_i,
   input  logic [LANES-1:0][N-1:0]   wd_i,
   input  logic [RW-1:0]             wa3_i,
   input  ctrl_t                     ctrl_i,
   output logic [LANES-1:0][N-1:0]   alu_o,
   output logic [LANES-1:0][N-1:0]   dir2_o,
   output logic [LANES-1:0][N-1:0]   dir3_o,
   output logic [LANES-1:0][N-1:0]   wd_o,
   output logic [RW-1:0]             wa3_o,
   output ctrl_t                     ctrl_o
);

   logic [LANES-1:0][N-1:0] alu_q, dir2_q, dir3_q, wd_q;
   logic [RW-1:0]           wa3_q;
   ctrl_t                   ctrl_q;

   // Capture the whole bundle when loaded; otherwise hold (flush only clears valid bits upstream)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_q  <= '0;
         dir2_q <= '0;
         dir3_q <= '0;
         wd_q   <= '0;
         wa3_q  <= '0;
         ctrl_q <= '0;
      end else if (load_i) begin
         alu_q  <= alu_i;
         dir2_q <= dir2_i;
         dir3_q <= dir3_i;
         wd_q   <= wd_i;
         wa3_q  <= wa3_i;
         ctrl_q <= ctrl_i;
      end
   end

   assign alu_o  = alu_q;
   assign dir2_o = dir2_q;
   assign dir3_o = dir3_q;
   assign wd_o   = wd_q;
   assign wa3_o  = wa3_q;
   assign ctrl_o = ctrl_q;

endmodule

// File: rtl/ex_mem_skid_buffer.sv
// rtl/ex_mem_skid_buffer.sv - EX/MEM pipeline register with one-entry skid slot, flush and stall counter
module ex_mem_skid_buffer
   import filter_gpu_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int LANES = LANES_DEF,
   parameter int RW    = RW_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES-1:0][N-1:0]   alu_result,
   input  logic [LANES-1:0][N-1:0]   mem_dir2,
   input  logic [LANES-1:0][N-1:0]   mem_dir3,
   input  logic [LANES-1:0][N-1:0]   write_data,
   input  logic [RW-1:0]             wa3,
   input  ctrl_t                     ctrl,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES-1:0][N-1:0]   q1,
   output logic [LANES-1:0][N-1:0]   q2,
   output logic [LANES-1:0][N-1:0]   q3,
   output logic [LANES-1:0][N-1:0]   write_data_o,
   output logic [RW-1:0]             wa3_o,
   output logic                      pcsrc_o,
   output logic                      regwrite_o,
   output logic                      memtoreg_o,
   output logic                      memwrite_o,
   output logic [CW-1:0]             stall_count
);

   logic main_valid_q, main_valid_d;
   logic skid_valid_q, skid_valid_d;
   logic [CW-1:0] stall_q, stall_d;
   logic main_ld, main_from_skid, skid_ld;
   logic acc, drn;

   logic [LANES-1:0][N-1:0] s_alu, s_dir2, s_dir3, s_wd;
   logic [RW-1:0]           s_wa3;
   ctrl_t                   s_ctrl;

   logic [LANES-1:0][N-1:0] m_alu_d, m_dir2_d, m_dir3_d, m_wd_d;
   logic [RW-1:0]           m_wa3_d;
   ctrl_t                   m_ctrl_d;
   ctrl_t                   m_ctrl;

   // Ready comes only from registered state so out_ready never reaches execute combinationally
   assign in_ready  = !skid_valid_q;
   assign out_valid = main_valid_q;
   assign acc       = in_valid & in_ready;
   assign drn       = main_valid_q & out_ready;

   // Slot control, highest priority first: flush, load main, refill from skid, park in skid
   always_comb begin
      main_valid_d   = main_valid_q;
      skid_valid_d   = skid_valid_q;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || (drn && !skid_valid_q)) begin
         main_valid_d = acc;
         main_ld      = acc;
      end else if (drn && skid_valid_q) begin
         main_ld        = 1'b1;
         main_from_skid = 1'b1;
         skid_valid_d   = 1'b0;
      end else if (acc) begin
         skid_ld      = 1'b1;
         skid_valid_d = 1'b1;
      end
   end

   // Main slot takes either the parked skid bundle or the live input
   always_comb begin
      m_alu_d  = main_from_skid ? s_alu  : alu_result;
      m_dir2_d = main_from_skid ? s_dir2 : mem_dir2;
      m_dir3_d = main_from_skid ? s_dir3 : mem_dir3;
      m_wd_d   = main_from_skid ? s_wd   : write_data;
      m_wa3_d  = main_from_skid ? s_wa3  : wa3;
      m_ctrl_d = main_from_skid ? s_ctrl : ctrl;
   end

   // Saturating count of cycles the memory stage holds off a valid bundle
   always_comb begin
      stall_d = stall_q;
      if (main_valid_q && !out_ready && (stall_q != {CW{1'b1}}))
         stall_d = stall_q + CW'(1);
   end

   // Valid bits and stall counter; flush leaves the counter alone
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         stall_q      <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         stall_q      <= stall_d;
      end
   end

   pipe_slot #(.N(N), .LANES(LANES), .RW(RW)) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load_i (skid_ld),
      .alu_i  (alu_result),
      .dir2_i (mem_dir2),
      .dir3_i (mem_dir3),
      .wd_i   (write_data),
      .wa3_i  (wa3),
      .ctrl_i (ctrl),
      .alu_o  (s_alu),
      .dir2_o (s_dir2),
      .dir3_o (s_dir3),
      .wd_o   (s_wd),
      .wa3_o  (s_wa3),
      .ctrl_o (s_ctrl)
   );

   pipe_slot #(.N(N), .LANES(LANES), .RW(RW)) u_main (
      .clk    (clk),
      .reset  (reset),
      .load_i (main_ld),
      .alu_i  (m_alu_d),
      .dir2_i (m_dir2_d),
      .dir3_i (m_dir3_d),
      .wd_i   (m_wd_d),
      .wa3_i  (m_wa3_d),
      .ctrl_i (m_ctrl_d),
      .alu_o  (q1),
      .dir2_o (q2),
      .dir3_o (q3),
      .wd_o   (write_data_o),
      .wa3_o  (wa3_o),
      .ctrl_o (m_ctrl)
   );

   // Stale or flushed bundles must never fire side effects downstream
   assign pcsrc_o     = m_ctrl.pcsrc    & main_valid_q;
   assign regwrite_o  = m_ctrl.regwrite & main_valid_q;
   assign memtoreg_o  = m_ctrl.memtoreg & main_valid_q;
   assign memwrite_o  = m_ctrl.memwrite & main_valid_q;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_ex_mem_skid_buffer.sv
// tb/tb_ex_mem_skid_buffer.sv - scoreboard bench for the EX/MEM skid buffer
module tb_ex_mem_skid_buffer;
   import filter_gpu_pkg::*;

   localparam int N  = 18;
   localparam int L  = 3;
   localparam int RW = 4;
   localparam int CW = 4;

   typedef struct packed {
      logic [L-1:0][N-1:0] a;
      logic [L-1:0][N-1:0] m2;
      logic [L-1:0][N-1:0] m3;
      logic [L-1:0][N-1:0] wd;
      logic [RW-1:0]       wa3;
      ctrl_t               c;
   } bundle_t;

   logic clk = 1'b0;
   logic reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [L-1:0][N-1:0] alu_result, mem_dir2, mem_dir3, write_data;
   logic [L-1:0][N-1:0] q1, q2, q3, write_data_o;
   logic [RW-1:0] wa3, wa3_o;
   ctrl_t ctrl;
   logic pcsrc_o, regwrite_o, memtoreg_o, memwrite_o;
   logic [CW-1:0] stall_count;

   int n_checks = 0;
   int n_fail   = 0;
   bundle_t sb[$];

   always #5 clk = ~clk;

   ex_mem_skid_buffer #(.N(N), .LANES(L), .RW(RW), .CW(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .alu_result   (alu_result),
      .mem_dir2     (mem_dir2),
      .mem_dir3     (mem_dir3),
      .write_data   (write_data),
      .wa3          (wa3),
      .ctrl         (ctrl),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .q1           (q1),
      .q2           (q2),
      .q3           (q3),
      .write_data_o (write_data_o),
      .wa3_o        (wa3_o),
      .pcsrc_o      (pcsrc_o),
      .regwrite_o   (regwrite_o),
      .memtoreg_o   (memtoreg_o),
      .memwrite_o   (memwrite_o),
      .stall_count  (stall_count)
   );

   function automatic bundle_t mk(input int base, input int w, input logic [3:0] c);
      bundle_t b;
      for (int i = 0; i < L; i++) begin
         b.a[i]  = N'(base + i);
         b.m2[i] = N'(base + 100 + i);
         b.m3[i] = N'(base + 200 + i);
         b.wd[i] = N'(base + 300 + i);
      end
      b.wa3 = RW'(w);
      b.c   = ctrl_t'(c);
      return b;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bundle_t b);
      alu_result = b.a;
      mem_dir2   = b.m2;
      mem_dir3   = b.m3;
      write_data = b.wd;
      wa3        = b.wa3;
      ctrl       = b.c;
   endtask

   // Offer a bundle until accepted; expected output is queued at the accepting edge
   task automatic send(input bundle_t b, output int waits);
      bit done = 0;
      drive(b);
      in_valid = 1'b1;
      waits = 0;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(b);
            @(posedge clk);
            #1;
            done = 1;
         end else begin
            @(posedge clk);
            #1;
            waits++;
            if (waits > 50) begin
               n_checks++;
               n_fail++;
               $display("FAIL send_timeout: in_ready stuck low, expected accept within 50 cycles");
               done = 1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every consumed bundle must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         bundle_t act, exp;
         act.a   = q1;
         act.m2  = q2;
         act.m3  = q3;
         act.wd  = write_data_o;
         act.wa3 = wa3_o;
         act.c   = ctrl_t'({pcsrc_o, regwrite_o, memtoreg_o, memwrite_o});
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got bundle %h, expected none", act);
         end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
               n_fail++;
               $display("FAIL sb_payload: got %h expected %h", act, exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      drive(mk(0, 0, 4'b0000));
      #12;
      chk("rst_in_ready",  in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_regwrite",  regwrite_o, 0);
      chk("rst_memwrite",  memwrite_o, 0);
      chk("rst_q1",        q1, 0);
      chk("rst_wa3",       wa3_o, 0);
      chk("rst_stall",     stall_count, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // single bundle, one-cycle latency
      out_ready = 1'b1;
      send(mk(5, 3, 4'b0100), w);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_q1_l0",     q1[0], 5);
      chk("t1_q1_l1",     q1[1], 6);
      chk("t1_q1_l2",     q1[2], 7);
      chk("t1_wa3",       wa3_o, 3);
      chk("t1_regwrite",  regwrite_o, 1);
      chk("t1_in_ready",  in_ready, 1);

      // back-to-back stream, no bubbles
      for (int k = 1; k <= 8; k++) begin
         send(mk(k, k, 4'b0100), w);
         chk("stream_waits",     w, 0);
         chk("stream_out_valid", out_valid, 1);
         chk("stream_q1_l0",     q1[0], k);
      end
      cycles(3);
      chk("stream_drained", sb.size(), 0);

      // stall with skid fill, then release
      do_reset();
      out_ready = 1'b0;
      send(mk(40, 1, 4'b0001), w);
      send(mk(44, 2, 4'b0100), w);
      chk("stall_in_ready_low", in_ready, 0);
      chk("stall_count_1",      stall_count, 1);
      chk("stall_main_is_a",    q1[0], 40);
      cycles(3);
      chk("stall_count_4",      stall_count, 4);
      out_ready = 1'b1;
      cycles(1);
      chk("skid_to_main_q1",    q1[0], 44);
      chk("skid_out_valid",     out_valid, 1);
      chk("skid_in_ready_back", in_ready, 1);
      chk("stall_count_held",   stall_count, 4);
      cycles(1);
      chk("stall_drained_ov",   out_valid, 0);
      chk("stall_sb_empty",     sb.size(), 0);

      // flush with both slots full
      do_reset();
      out_ready = 1'b0;
      send(mk(20, 7, 4'b0101), w);
      send(mk(30, 8, 4'b0101), w);
      drive(mk(90, 9, 4'b0101));
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      chk("flush_out_valid", out_valid, 0);
      chk("flush_regwrite",  regwrite_o, 0);
      chk("flush_memwrite",  memwrite_o, 0);
      chk("flush_in_ready",  in_ready, 1);
      chk("flush_hold_q1",   q1[0], 20);
      chk("flush_stall_kept", stall_count, 2);
      out_ready = 1'b1;
      cycles(3);
      chk("flush_no_ghost",  out_valid, 0);

      // flush while an accept would otherwise happen
      out_ready = 1'b0;
      send(mk(50, 4, 4'b0100), w);
      drive(mk(70, 5, 4'b0100));
      in_valid = 1'b1;
      flush    = 1'b1;
      @(negedge clk);
      chk("flush_acc_ready", in_ready, 1);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      chk("flush_acc_ov",    out_valid, 0);
      chk("flush_acc_q1",    q1[0], 50);
      out_ready = 1'b1;
      cycles(2);
      chk("flush_acc_ghost", out_valid, 0);

      // stall counter saturation
      do_reset();
      out_ready = 1'b0;
      send(mk(11, 6, 4'b0001), w);
      cycles(14);
      chk("sat_14", stall_count, 14);
      cycles(7);
      chk("sat_15", stall_count, 15);
      send(mk(12, 2, 4'b0100), w);
      chk("sat_full_ready", in_ready, 0);

      // asynchronous reset between edges while full
      #2;
      reset = 1'b1;
      #1;
      chk("areset_out_valid", out_valid, 0);
      chk("areset_in_ready",  in_ready, 1);
      chk("areset_q1",        q1, 0);
      chk("areset_q3",        q3, 0);
      chk("areset_wd",        write_data_o, 0);
      chk("areset_wa3",       wa3_o, 0);
      chk("areset_memwrite",  memwrite_o, 0);
      chk("areset_stall",     stall_count, 0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(mk(60, 9, 4'b1010), w);
      chk("post_rst_ov",   out_valid, 1);
      chk("post_rst_q1",   q1[0], 60);
      chk("post_rst_pcsrc", pcsrc_o, 1);
      cycles(3);
      chk("final_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_mem_skid_buffer.md
Name: ex_mem_skid_buffer

Overview:
Parametrised EX/MEM pipeline register for the Filter-GPU vector datapath. It carries per-lane ALU result, two memory addresses and store data, plus the write-back register index and control bits. It adds a valid/ready handshake with a one-entry skid slot, so the memory stage can stall without a combinational ready path back into execute. It also adds a synchronous flush and a saturating stall counter for profiling.

Parameters:
N, 18, data width per lane
LANES, 3, number of vector lanes
RW, 4, register index width (WA3)
CW, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  execute stage presents a bundle
in_ready  out  1  buffer can accept a bundle this cycle
alu_result  in  N x LANES  per-lane ALU result
mem_dir2  in  N x LANES  per-lane memory direction 2
mem_dir3  in  N x LANES  per-lane memory direction 3
write_data  in  N x LANES  per-lane store data
wa3  in  RW  write-back register index
ctrl  in  ctrl_t  {pcsrc, regwrite, memtoreg, memwrite}
out_valid  out  1  bundle presented to memory stage
out_ready  in  1  memory stage consumes bundle
q1, q2, q3, write_data_o  out  N x LANES  registered payload of main slot
wa3_o  out  RW  registered index
pcsrc_o, regwrite_o, memtoreg_o, memwrite_o  out  1  control, gated by out_valid
stall_count  out  CW  saturating count of stall cycles

Behaviour:
- Storage: main slot (drives outputs) and skid slot. Each slot holds the payload plus a valid bit.
- Reset (async, reset=1): both valid bits 0; all payload registers, wa3_o and stall_count 0. After reset: in_ready=1, out_valid=0, all control outputs 0.
- in_ready = !skid_valid. It depends only on registered state and has no combinational path from out_ready.
- out_valid = main_valid.
- Control outputs are the stored control bit AND main_valid. An invalid or flushed entry never asserts regwrite_o or memwrite_o.
- Accept condition: acc = in_valid & in_ready. Drain condition: drn = out_valid & out_ready.
- Per-cycle update, priority order:
  1. flush=1: main_valid<=0 and skid_valid<=0. The input is ignored even when acc=1. Payload registers hold their values. stall_count still updates.
  2. main empty, or drn=1 with skid empty: on acc, the input loads the main slot (main_valid<=1); otherwise main_valid<=0. Latency input to output is 1 cycle.
  3. drn=1 with skid full: the skid slot moves to main and skid_valid<=0. On the same cycle in_ready=0, so no accept.
  4. main full, no drain, acc=1: the input loads the skid slot (skid_valid<=1).
  5. Otherwise: hold.
- Ordering: bundles leave in acceptance order. No bundle is duplicated or dropped except by flush.
- stall_count: increments when out_valid & !out_ready, saturates at 2^CW-1, never wraps. It resets only on reset and is not cleared by flush.
- Lane independence: lane i of every array maps only to lane i; no cross-lane mixing.
- Reset asserted mid-stall: everything clears immediately (async). The first accept after reset deasserts follows rule 2.

Decomposition:
- Package filter_gpu_pkg holds:
  - ctrl_t packed struct {pcsrc, regwrite, memtoreg, memwrite}
  - default constants LANES_DEF=3, N_DEF=18, RW_DEF=4
- One sub-module, pipe_slot: an enable-loaded payload register (LANES x 4 arrays of N bits + wa3 + ctrl_t) with async reset to 0. It is instantiated twice, as main and skid.
- The handshake and valid logic stays in the parent.

Test Plan:
- Reset release, in_valid=1, alu_result={5,6,7}, wa3=3, ctrl.regwrite=1, out_ready=1 -> next cycle: out_valid=1, q1={5,6,7}, wa3_o=3, regwrite_o=1; in_ready stays 1.
- Back-to-back stream of 8 bundles (values 1..8) with out_ready=1 -> q1[0] sequence is 1..8 on consecutive cycles, no bubbles.
- Send A, then B while out_ready=0 -> in_ready falls to 0 after B; stall_count increments each stalled cycle. Raise out_ready -> A, then B emerge; in_ready returns to 1 after the skid slot drains.
- Main and skid both full, flush=1 with in_valid=1 -> next cycle: out_valid=0, memwrite_o=0, regwrite_o=0, in_ready=1; the flushed input does not appear.
- Hold out_valid=1, out_ready=0 for 2^CW+5 cycles with CW=4 -> stall_count saturates at 15.
- Assert reset asynchronously between clock edges while full -> outputs zero immediately, before the next clk edge.
